logic_unit_pipe: RTL

- Parametrised, registered successor to the standalone AND/OR/NOT gate primitives.
- Applies one of eight bitwise functions to WIDTH-bit operands under a valid/ready handshake.
- Supports an accumulate mode that folds operand a into an internal register.
- Produces result flags and a saturating transaction count; used as the bitwise datapath slice in larger logic experiments.

---
 rtl/logic_pkg.sv | 38 +++
 rtl/logic_op_comb.sv | 20 ++
 rtl/logic_unit_pipe.sv | 116 +++++++++++
 3 files changed

// File: rtl/logic_pkg.sv
// Shared op codes and the per-bit function table for the bitwise datapath slice.
// Lanes of any width apply op_bit column by column, so one definition serves all widths.
package logic_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'b000;
    localparam logic [OP_W-1:0] OP_OR   = 3'b001;
    localparam logic [OP_W-1:0] OP_NOT  = 3'b010;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b011;
    localparam logic [OP_W-1:0] OP_NAND = 3'b100;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b101;
    localparam logic [OP_W-1:0] OP_XNOR = 3'b110;
    localparam logic [OP_W-1:0] OP_PASS = 3'b111;

    // NOT and PASS look only at the left operand.
    function automatic logic op_bit(
        input logic [OP_W-1:0] op,
        input logic            x,
        input logic            y
    );
        logic r;
        r = 1'b0;
        case (op)
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_NOT:  r = ~x;
            OP_XOR:  r = x ^ y;
            OP_NAND: r = ~(x & y);
            OP_NOR:  r = ~(x | y);
            OP_XNOR: r = ~(x ^ y);
            OP_PASS: r = x;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_op_comb.sv
// Purely combinational bitwise function lane: y_out = op(x, y) at WIDTH bits.
// Kept separate so a multi-lane wrapper can instantiate one per lane.
module logic_op_comb
    import logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_out
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        always_comb begin
            y_out[i] = op_bit(op, x[i], y[i]);
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise unit with valid/ready handshake, accumulator, result flags
// and a saturating count of accepted beats.
module logic_unit_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_op,
    input  logic               in_acc,
    input  logic               in_clr,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_y,
    output logic               out_zero,
    output logic               out_ones,
    output logic               out_parity,
    output logic [COUNT_W-1:0] out_count
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    logic               out_valid_q,  out_valid_d;
    logic [WIDTH-1:0]   out_y_q,      out_y_d;
    logic               out_zero_q,   out_zero_d;
    logic               out_ones_q,   out_ones_d;
    logic               out_parity_q, out_parity_d;
    logic [COUNT_W-1:0] count_q,      count_d;
    logic [WIDTH-1:0]   acc_q,        acc_d;

    logic               fire;
    logic [WIDTH-1:0]   acc_eff;
    logic [WIDTH-1:0]   rhs;
    logic [WIDTH-1:0]   result;

    // Ready is combinational on out_ready so a draining beat frees the slot
    // in the same cycle and back-to-back beats run at full rate.
    always_comb begin
        in_ready = !out_valid_q || out_ready;
        fire     = in_valid && in_ready;
        acc_eff  = in_clr ? '0 : acc_q;
        rhs      = in_acc ? acc_eff : in_b;
    end

    logic_op_comb #(
        .WIDTH (WIDTH)
    ) u_op (
        .op    (in_op),
        .x     (in_a),
        .y     (rhs),
        .y_out (result)
    );

    always_comb begin
        out_valid_d  = out_valid_q;
        out_y_d      = out_y_q;
        out_zero_d   = out_zero_q;
        out_ones_d   = out_ones_q;
        out_parity_d = out_parity_q;
        count_d      = count_q;
        acc_d        = acc_q;

        if (fire) begin
            out_valid_d  = 1'b1;
            out_y_d      = result;
            out_zero_d   = (result == '0);
            out_ones_d   = (result == {WIDTH{1'b1}});
            out_parity_d = ^result;
            if (count_q != COUNT_MAX) begin
                count_d = count_q + 1'b1;
            end
            if (in_acc) begin
                acc_d = result;
            end else if (in_clr) begin
                acc_d = '0;
            end
        end else if (out_ready) begin
            // Drain only: the last result stays visible on out_y.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_y_q      <= '0;
            out_zero_q   <= 1'b0;
            out_ones_q   <= 1'b0;
            out_parity_q <= 1'b0;
            count_q      <= '0;
            acc_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_y_q      <= out_y_d;
            out_zero_q   <= out_zero_d;
            out_ones_q   <= out_ones_d;
            out_parity_q <= out_parity_d;
            count_q      <= count_d;
            acc_q        <= acc_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_y      = out_y_q;
    assign out_zero   = out_zero_q;
    assign out_ones   = out_ones_q;
    assign out_parity = out_parity_q;
    assign out_count  = count_q;

endmodule
